ofm_writeback_ctrl: RTL and testbench
=====================================

// Module: ofm_writeback_ctrl
// PURPOSE
//  Write-back sequencer for the 16-lane feature-map DPRAM. Accepts 16-pixel beats from the systolic array
//  (valid/ready) in channel-major, row-major, left-to-right order. Drives the DPRAM write port: we_b, addr_b,
//  din_b, write_ofm_size, upsample_mode, ofm_size. Handles partial last tiles, 2x upsample stride, overflow, abort.
// PARAMETERS
//  RAM_SIZE       524172  DPRAM depth in pixels
//  ADDR_WIDTH     19      $clog2(RAM_SIZE); width of all pixel addresses
//  DATA_WIDTH     16      bits per pixel
//  SYSTOLIC_SIZE  16      pixels per beat
//  INOUT_WIDTH    256     DATA_WIDTH*SYSTOLIC_SIZE
// PORTS
//  clk            in   1           clock; all logic on rising edge
//  rst_n          in   1           synchronous active-low reset
//  start          in   1           1-cycle pulse; latches cfg_*; ignored unless IDLE
//  abort          in   1           return to IDLE at next edge, no done pulse
//  cfg_base_addr  in   ADDR_WIDTH  pixel address of channel 0, row 0, col 0
//  cfg_ofm_size   in   9           OFM width = height-stride in pixels (input geometry, pre-upsample)
//  cfg_num_rows   in   9           rows per channel
//  cfg_num_ch     in   10          channels
//  cfg_upsample   in   1           1: 2x nearest-neighbour upsample on write
//  in_valid       in   1           beat valid
//  in_data        in   INOUT_WIDTH lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_ready       out  1           = (state==RUN)
//  we_b/addr_b/din_b/write_ofm_size[4:0]/upsample_mode/ofm_size[8:0]  out  to DPRAM port B
//  busy           out  1           state != IDLE
//  done           out  1           1-cycle pulse at end of job
//  err_overflow   out  1           sticky; cleared by accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (incl. err_overflow); counters 0.
//  FSM IDLE->RUN on start; if cfg_ofm_size, cfg_num_rows or cfg_num_ch is 0 -> DONE instead (no writes).
//   RUN->DONE on acceptance of last beat; DONE->IDLE unconditionally (done=1 in DONE only).
//   abort in any state -> IDLE next edge, we_b of the aborted cycle's beat not issued; abort beats start.
//  Beat accepted when in_valid&&in_ready. One registered write per accepted beat; 1-cycle latency:
//   we_b=1 exactly in the cycle after acceptance, else 0. din_b=in_data registered.
//  Counters col (step 16), row, ch; n = min(16, S-col), S=cfg_ofm_size; write_ofm_size=n (1..16).
//   col wraps to 0 at >=S -> row++; row wraps at cfg_num_rows -> ch++. Last beat: final col/row/ch.
//  Addresses kept incrementally (no multipliers); O = S (normal) or 2S (upsample):
//   normal:   addr = base + ch*S*R + row*S + col
//   upsample: addr = base + ch*4*S*R + row*2*O + 2*col; ofm_size output = O = 2S.
//  upsample_mode and ofm_size held from start until next start (stable through job).
//  Upsample with S>255 (O overflows 9 bits): set err_overflow at start, go DONE, no writes.
//  Overflow check per beat: last pixel = addr+n-1 (normal) or addr+O+2n-1 (upsample);
//   if >= RAM_SIZE: suppress we_b for that beat, set err_overflow; beat still consumed, counters advance.
//  Internal address arithmetic at ADDR_WIDTH+2 bits so the check never aliases.
//  start while busy: ignored, cfg unchanged.
// TESTING
//  1 base=100,S=20,R=2,C=1,up=0: 4 beats -> (addr,size)=(100,16),(116,4),(120,16),(136,4); done 1 cyc after last we_b.
//  2 base=0,S=13,R=2,C=2,up=1: ofm_size=26; addr_b 0,52,104,156, size 13 each; mem rows 0..7 replicated.
//  3 Case 1 with in_valid random 50%: we_b count=4, addresses identical, none issued without acceptance.
//  4 R=0 start -> done pulse 2 cycles after start, in_ready never 1, we_b never 1.
//  5 base=524160,S=16,R=1,C=1,up=0: beat accepted, we_b stays 0, err_overflow=1, done pulses; next start clears.
//  6 abort after beat 2 of case 1, then rst_n=0 mid-second job: IDLE, outputs 0, no done; fresh job correct.

Source files
------------

// File: rtl/ofm_writeback_ctrl_if.sv
// Pixel-beat stream in from the systolic array plus the DPRAM port-B write bus.
// master drives the beats and observes the writes; slave is the write-back sequencer.
interface ofm_writeback_ctrl_if #(
  parameter int ADDR_WIDTH  = 19,
  parameter int INOUT_WIDTH = 256
);
  logic                   in_valid;
  logic [INOUT_WIDTH-1:0] in_data;
  logic                   in_ready;
  logic                   we_b;
  logic [ADDR_WIDTH-1:0]  addr_b;
  logic [INOUT_WIDTH-1:0] din_b;
  logic [4:0]             write_ofm_size;
  logic                   upsample_mode;
  logic [8:0]             ofm_size;

  modport master (
    output in_valid, in_data,
    input  in_ready, we_b, addr_b, din_b, write_ofm_size, upsample_mode, ofm_size
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we_b, addr_b, din_b, write_ofm_size, upsample_mode, ofm_size
  );
endinterface

// File: rtl/ofm_writeback_ctrl.sv
// OFM write-back sequencer: one DPRAM write per accepted 16-pixel beat, 1-cycle registered latency.
// Backpressure: in_ready is high for the whole RUN state; beats that would overflow the RAM are consumed but not written.
module ofm_writeback_ctrl #(
  parameter int RAM_SIZE      = 524172,
  parameter int ADDR_WIDTH    = 19,
  parameter int DATA_WIDTH    = 16,
  parameter int SYSTOLIC_SIZE = 16,
  parameter int INOUT_WIDTH   = DATA_WIDTH * SYSTOLIC_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [8:0]            cfg_ofm_size,
  input  logic [8:0]            cfg_num_rows,
  input  logic [9:0]            cfg_num_ch,
  input  logic                  cfg_upsample,
  ofm_writeback_ctrl_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow
);
  localparam int AW2 = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  state_e state_q, state_d;

  logic [8:0]             s_q, s_d, r_q, r_d, ofm_q, ofm_d, col_q, col_d, row_q, row_d;
  logic [9:0]             c_q, c_d, ch_q, ch_d;
  logic                   up_q, up_d, err_q, err_d, we_q, we_d, done_q, done_d;
  logic [AW2-1:0]         row_addr_q, row_addr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INOUT_WIDTH-1:0] din_q, din_d;
  logic [4:0]             wsize_q, wsize_d;

  logic [9:0]     rem, col_nx;
  logic [4:0]     n;
  logic           row_wrap, row_last, ch_last, last_beat, accept, start_acc;
  logic           cfg_empty, cfg_bad, beat_ovf;
  logic [AW2-1:0] beat_addr, row_step, o_ext, last_px;

  // row_addr_q tracks the first pixel of the current row; stepping past a channel's
  // last row lands exactly on the next channel's origin, so no channel base is kept.
  always_comb begin
    rem       = {1'b0, s_q} - {1'b0, col_q};
    n         = (rem >= 10'd16) ? 5'd16 : rem[4:0];
    col_nx    = {1'b0, col_q} + 10'd16;
    row_wrap  = (col_nx >= {1'b0, s_q});
    row_last  = (row_q == r_q - 9'd1);
    ch_last   = (ch_q == c_q - 10'd1);
    last_beat = row_wrap && row_last && ch_last;
    beat_addr = row_addr_q + (up_q ? AW2'({col_q, 1'b0}) : AW2'(col_q));
    row_step  = up_q ? AW2'({s_q, 2'b00}) : AW2'(s_q);
    o_ext     = up_q ? AW2'({s_q, 1'b0}) : AW2'(s_q);
    last_px   = up_q ? beat_addr + o_ext + AW2'({n, 1'b0}) - AW2'(1)
                     : beat_addr + AW2'(n) - AW2'(1);
    beat_ovf  = (last_px >= AW2'(RAM_SIZE));
    accept    = bus.in_valid && (state_q == RUN);
    start_acc = start && (state_q == IDLE) && !abort;
    cfg_empty = (cfg_ofm_size == 9'd0) || (cfg_num_rows == 9'd0) || (cfg_num_ch == 10'd0);
    cfg_bad   = cfg_upsample && cfg_ofm_size[8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (cfg_empty || cfg_bad) ? DONE : RUN;
      RUN:     if (accept && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    bus.in_ready       = (state_q == RUN);
    busy               = (state_q != IDLE);
    done               = done_q;
    err_overflow       = err_q;
    bus.we_b           = we_q;
    bus.addr_b         = addr_q;
    bus.din_b          = din_q;
    bus.write_ofm_size = wsize_q;
    bus.upsample_mode  = up_q;
    bus.ofm_size       = ofm_q;
  end

  always_comb begin
    s_d        = s_q;
    r_d        = r_q;
    c_d        = c_q;
    up_d       = up_q;
    ofm_d      = ofm_q;
    col_d      = col_q;
    row_d      = row_q;
    ch_d       = ch_q;
    row_addr_d = row_addr_q;
    err_d      = err_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    wsize_d    = wsize_q;
    done_d     = (state_q == DONE) && !abort;
    if (start_acc) begin
      s_d        = cfg_ofm_size;
      r_d        = cfg_num_rows;
      c_d        = cfg_num_ch;
      up_d       = cfg_upsample;
      ofm_d      = cfg_upsample ? {cfg_ofm_size[7:0], 1'b0} : cfg_ofm_size;
      col_d      = '0;
      row_d      = '0;
      ch_d       = '0;
      row_addr_d = AW2'(cfg_base_addr);
      err_d      = cfg_bad;
    end
    if (accept && !abort) begin
      we_d    = !beat_ovf;
      addr_d  = beat_addr[ADDR_WIDTH-1:0];
      din_d   = bus.in_data;
      wsize_d = n;
      err_d   = err_q | beat_ovf;
      if (row_wrap) begin
        col_d      = '0;
        row_addr_d = row_addr_q + row_step;
        if (row_last) begin
          row_d = '0;
          ch_d  = ch_q + 10'd1;
        end else begin
          row_d = row_q + 9'd1;
        end
      end else begin
        col_d = col_nx[8:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= '0; r_q <= '0; c_q <= '0; up_q <= 1'b0; ofm_q <= '0;
      col_q <= '0; row_q <= '0; ch_q <= '0; row_addr_q <= '0;
      err_q <= 1'b0; we_q <= 1'b0; addr_q <= '0; din_q <= '0; wsize_q <= '0; done_q <= 1'b0;
    end else begin
      s_q <= s_d; r_q <= r_d; c_q <= c_d; up_q <= up_d; ofm_q <= ofm_d;
      col_q <= col_d; row_q <= row_d; ch_q <= ch_d; row_addr_q <= row_addr_d;
      err_q <= err_d; we_q <= we_d; addr_q <= addr_d; din_q <= din_d; wsize_q <= wsize_d; done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_ofm_writeback_ctrl.sv
// Randomized bench for ofm_writeback_ctrl against a closed-form address/overflow model.
module tb_ofm_writeback_ctrl;
  localparam int AW       = 19;
  localparam int IW       = 256;
  localparam int RAM_SIZE = 524172;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [8:0]    cfg_ofm_size = '0;
  logic [8:0]    cfg_num_rows = '0;
  logic [9:0]    cfg_num_ch = '0;
  logic          cfg_upsample = 1'b0;
  logic          busy, done, err_overflow;

  ofm_writeback_ctrl_if bus ();

  ofm_writeback_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_ofm_size(cfg_ofm_size), .cfg_num_rows(cfg_num_rows),
    .cfg_num_ch(cfg_num_ch), .cfg_upsample(cfg_upsample), .bus(bus),
    .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_we_cyc = 0, start_cyc = 0, rdy_cnt = 0;

  longint         exp_addr[$];
  int             exp_size[$];
  logic [IW-1:0]  exp_din[$];
  longint         obs_addr[$];
  int             obs_size[$];
  logic [IW-1:0]  obs_din[$];

  task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.we_b === 1'b1) begin
      obs_addr.push_back(longint'(bus.addr_b));
      obs_size.push_back(int'(bus.write_ofm_size));
      obs_din.push_back(bus.din_b);
      last_we_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.in_ready === 1'b1) rdy_cnt++;
    if (start) start_cyc = cyc;
  end

  function automatic logic [IW-1:0] rand_beat();
    logic [IW-1:0] d;
    for (int k = 0; k < IW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic pulse_start(input int base, input int s, input int r, input int c, input bit up);
    @(posedge clk); #1;
    cfg_base_addr = AW'(base);
    cfg_ofm_size  = 9'(s);
    cfg_num_rows  = 9'(r);
    cfg_num_ch    = 10'(c);
    cfg_upsample  = up;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int base, input int s, input int r, input int c, input bit up,
                         input int vpct, input int abort_after);
    longint o, a, lp;
    longint bq_addr[$];
    int     bq_n[$];
    bit     bq_ovf[$];
    int     n, nb, i, guard;
    bit     v, eerr;
    logic [IW-1:0] d;
    exp_addr.delete(); exp_size.delete(); exp_din.delete();
    obs_addr.delete(); obs_size.delete(); obs_din.delete();
    done_cnt = 0;
    rdy_cnt  = 0;
    o    = up ? 2 * s : s;
    eerr = up && (s > 255);
    if (!(s == 0 || r == 0 || c == 0 || eerr)) begin
      for (int ch = 0; ch < c; ch++)
        for (int row = 0; row < r; row++)
          for (int col = 0; col < s; col += 16) begin
            n  = (s - col < 16) ? s - col : 16;
            a  = up ? longint'(base) + longint'(ch) * 4 * s * r + longint'(row) * 2 * o + 2 * col
                    : longint'(base) + longint'(ch) * s * r + longint'(row) * s + col;
            lp = up ? a + o + 2 * n - 1 : a + n - 1;
            bq_addr.push_back(a);
            bq_n.push_back(n);
            bq_ovf.push_back(lp >= RAM_SIZE);
            if (lp >= RAM_SIZE) eerr = 1'b1;
          end
    end
    nb = bq_addr.size();
    pulse_start(base, s, r, c, up);
    chk("err_at_start", err_overflow, up && (s > 255));
    i = 0;
    guard = 0;
    while (i < nb && !(abort_after >= 0 && i == abort_after)) begin
      v = ($urandom_range(99) < vpct);
      d = rand_beat();
      bus.in_valid = v;
      bus.in_data  = d;
      if (v && bus.in_ready) begin
        if (!bq_ovf[i]) begin
          exp_addr.push_back(bq_addr[i]);
          exp_size.push_back(bq_n[i]);
          exp_din.push_back(d);
        end
        i++;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 4000) begin
        chk("beat_budget", i, nb);
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (abort_after >= 0 && i == abort_after) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rand_beat();
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_writes", obs_addr.size(), abort_after);
      return;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("n_writes", obs_addr.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      chk($sformatf("addr[%0d]", k), obs_addr[k], exp_addr[k]);
      chk($sformatf("size[%0d]", k), obs_size[k], exp_size[k]);
      chk($sformatf("din[%0d]", k), obs_din[k], exp_din[k]);
    end
    chk("err_overflow", err_overflow, eerr);
    chk("ofm_size", bus.ofm_size, o & 511);
    chk("upsample_mode", bus.upsample_mode, up);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_b", bus.we_b, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_ofm_size", bus.ofm_size, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(100, 20, 2, 1, 1'b0, 100, -1);
    chk("c1_nw", obs_addr.size(), 4);
    if (obs_addr.size() == 4) begin
      chk("c1_a0", obs_addr[0], 100); chk("c1_s0", obs_size[0], 16);
      chk("c1_a1", obs_addr[1], 116); chk("c1_s1", obs_size[1], 4);
      chk("c1_a2", obs_addr[2], 120); chk("c1_s2", obs_size[2], 16);
      chk("c1_a3", obs_addr[3], 136); chk("c1_s3", obs_size[3], 4);
    end
    chk("c1_done_lat", done_cyc, last_we_cyc + 1);

    run_job(0, 13, 2, 2, 1'b1, 100, -1);
    chk("c2_ofm", bus.ofm_size, 26);
    if (obs_addr.size() == 4) begin
      chk("c2_a1", obs_addr[1], 52);
      chk("c2_a2", obs_addr[2], 104);
      chk("c2_a3", obs_addr[3], 156);
      chk("c2_s3", obs_size[3], 13);
    end

    run_job(100, 20, 2, 1, 1'b0, 50, -1);
    chk("c3_nw", obs_addr.size(), 4);

    run_job(0, 20, 0, 1, 1'b0, 100, -1);
    chk("c4_done_lat", done_cyc, start_cyc + 2);
    chk("c4_ready", rdy_cnt, 0);

    run_job(524160, 16, 1, 1, 1'b0, 100, -1);
    chk("c5_err", err_overflow, 1'b1);
    chk("c5_nw", obs_addr.size(), 0);

    run_job(0, 300, 1, 1, 1'b1, 100, -1);
    chk("up_big_err", err_overflow, 1'b1);

    run_job(100, 20, 2, 1, 1'b0, 100, 2);

    pulse_start(100, 20, 2, 1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = rand_beat();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    done_cnt = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_we_b", bus.we_b, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", bus.in_ready, 1'b0);
    chk("mid_rst_up", bus.upsample_mode, 1'b0);
    chk("mid_rst_ofm", bus.ofm_size, 0);
    chk("mid_rst_wsize", bus.write_ofm_size, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt, 0);

    run_job(100, 20, 2, 1, 1'b0, 100, -1);

    for (int t = 0; t < 10; t++) begin
      int base;
      base = ($urandom_range(3) == 0) ? RAM_SIZE - int'($urandom_range(1, 300))
                                      : int'($urandom_range(0, 5000));
      run_job(base, int'($urandom_range(1, 40)), int'($urandom_range(1, 3)),
              int'($urandom_range(1, 3)), 1'($urandom_range(1)), 60, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
